// File: rtl/yduck_dbus.sv
// yduck_dbus: single-port data bus for the Yduck core.
// Decodes one word address into an internal data RAM and a small GPIO block.
// One access per clock: we=1 writes din, we=0 reads into the registered dout.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   din       write data
//   addr      word address of the current access
//   we        1 = write, 0 = read
//   dout      registered read data (1-cycle latency)
//   gpio_in   external input pins
//   gpio_out  registered output pins
//
// Address map: RAM at 0 .. 2^RAM_AW-1, GPIO_IN at GPIO_BASE (read-only),
// GPIO_OUT at GPIO_BASE+1 (read/write); everything else reads as 0.
//
// Optional feature macro: DBUS_GPIO_SYNC_EN
//   When defined, gpio_in passes through a 2-flop synchronizer before the
//   read mux (pin-to-dout latency 3 cycles). When undefined, gpio_in is
//   sampled directly at the read edge.

module yduck_dbus #(
    parameter int unsigned   DW        = 16,
    parameter int unsigned   AW        = 16,
    parameter int unsigned   RAM_AW    = 8,
    parameter logic [AW-1:0] GPIO_BASE = AW'(16'h2000)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] addr,
    input  logic          we,
    output logic [DW-1:0] dout,
    input  logic [DW-1:0] gpio_in,
    output logic [DW-1:0] gpio_out
);

    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

    logic [DW-1:0]     ram [RAM_DEPTH];
    logic [RAM_AW-1:0] ram_idx_c;
    logic              ram_sel_c;
    logic              gin_sel_c;
    logic              gout_sel_c;
    logic [DW-1:0]     gpio_in_s;
    logic [DW-1:0]     rd_data_c;

    // Full-width decode: RAM is not aliased above its depth.
    assign ram_idx_c  = addr[RAM_AW-1:0];
    assign ram_sel_c  = (addr[AW-1:RAM_AW] == '0);
    assign gin_sel_c  = (addr == GPIO_BASE);
    assign gout_sel_c = (addr == GPIO_BASE + AW'(1));

`ifdef DBUS_GPIO_SYNC_EN
    logic [DW-1:0] gpio_meta;

    // Two-flop synchronizer for asynchronous input pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_meta <= '0;
            gpio_in_s <= '0;
        end else begin
            gpio_meta <= gpio_in;
            gpio_in_s <= gpio_meta;
        end
    end
`else
    assign gpio_in_s = gpio_in;
`endif

    // RAM storage; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && we && ram_sel_c) begin
            ram[ram_idx_c] <= din;
        end
    end

    // Read data mux; unmapped addresses return zero.
    always_comb begin
        rd_data_c = '0;
        if (ram_sel_c) begin
            rd_data_c = ram[ram_idx_c];
        end else if (gin_sel_c) begin
            rd_data_c = gpio_in_s;
        end else if (gout_sel_c) begin
            rd_data_c = gpio_out;
        end
    end

    // Registered read data and output pins; dout holds during writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout     <= '0;
            gpio_out <= '0;
        end else begin
            if (!we) begin
                dout <= rd_data_c;
            end
            if (we && gout_sel_c) begin
                gpio_out <= din;
            end
        end
    end

endmodule

// File: tb/tb_yduck_dbus.sv
// Directed self-checking bench for yduck_dbus. Inputs change on the falling
// edge, the DUT samples on the rising edge, and results are checked on the
// following falling edge. Read expectations go through a scoreboard queue.

module tb_yduck_dbus;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic [15:0] addr;
    logic        we;
    logic [15:0] dout;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    yduck_dbus dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .addr     (addr),
        .we       (we),
        .dout     (dout),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, let the rising edge sample, return at falling edge.
    task automatic cyc(input logic w, input logic [15:0] a, input logic [15:0] d);
        we   = w;
        addr = a;
        din  = d;
        @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cyc(1'b1, a, d);
    endtask

    // Read: push the expectation, run the cycle, then pop and compare.
    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
        logic [15:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        cyc(1'b0, a, 16'h0000);
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $error("FAIL %s: observed=empty-scoreboard expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, dout, e);
        end
    endtask

    initial begin
        rst     = 1'b0;
        we      = 1'b0;
        addr    = 16'h0000;
        din     = 16'h0000;
        gpio_in = 16'h0000;

        // Reset state is immediate and held for two cycles.
        #1;
        check("rst_dout_imm", dout, 16'h0000);
        check("rst_gpio_imm", gpio_out, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("rst_dout_hold", dout, 16'h0000);
        check("rst_gpio_hold", gpio_out, 16'h0000);
        rst = 1'b1;

        // RAM write/readback.
        wr(16'h0000, 16'h0030);
        wr(16'h0001, 16'h0031);
        rd(16'h0001, 16'h0031, "ram_rd1");
        rd(16'h0000, 16'h0030, "ram_rd0");

        // Write then read the same address; dout holds across the write.
        wr(16'h0002, 16'h0032);
        check("dout_hold_wr", dout, 16'h0030);
        rd(16'h0002, 16'h0032, "ram_wr_rd");
        check("gpio_no_spurious", gpio_out, 16'h0000);

        // RAM top word boundary.
        wr(16'h00FF, 16'hA5FF);
        rd(16'h00FF, 16'hA5FF, "ram_top");

        // GPIO input.
`ifdef DBUS_GPIO_SYNC_EN
        gpio_in = 16'h001A;
        rd(16'h3000, 16'h0000, "sync_fill0");
        rd(16'h3000, 16'h0000, "sync_fill1");
        rd(16'h2000, 16'h001A, "gpio_in_sync");
`else
        gpio_in = 16'h001A;
        rd(16'h2000, 16'h001A, "gpio_in_1a");
        gpio_in = 16'h0005;
        rd(16'h2000, 16'h0005, "gpio_in_05");
`endif

        // GPIO output.
        wr(16'h2001, 16'h003C);
        check("gpio_out_wr", gpio_out, 16'h003C);
        rd(16'h2001, 16'h003C, "gpio_out_rd");
        rd(16'h0001, 16'h0031, "ram_rd1_again");

        // Unmapped and read-only writes have no side effect.
        wr(16'h2000, 16'hFFFF);
        wr(16'h0100, 16'h1234);
        rd(16'h0100, 16'h0000, "unmapped_0100");
        rd(16'h0000, 16'h0030, "ram0_intact");
        check("gpio_out_unchanged", gpio_out, 16'h003C);
        rd(16'h2002, 16'h0000, "unmapped_2002");
        rd(16'hFFFF, 16'h0000, "unmapped_ffff");

        // Reset asserted mid-write: outputs clear at once, the write is dropped.
        wr(16'h0003, 16'h0033);
        we   = 1'b1;
        addr = 16'h0003;
        din  = 16'hBEEF;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_gpio_imm", gpio_out, 16'h0000);
        check("midrst_dout_imm", dout, 16'h0000);
        @(negedge clk);
        check("midrst_gpio_edge", gpio_out, 16'h0000);
        rst = 1'b1;
        rd(16'h0003, 16'h0033, "midrst_wr_dropped");
        rd(16'h2001, 16'h0000, "midrst_gpio_rd");

        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $error("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
